waveform_playback: RTL

Transmit-side counterpart of the capture path. Accepts bytes from the host (UART RX deframer) on a valid/ready byte interface, buffers them in a small FIFO, and serializes them MSB-first onto a single digital line (`wave_out`). It drives the TDR stimulus pattern. Back-to-back bytes are emitted with no gap between bits, so a byte stream produced by the capture block replays as the original waveform.

---
 rtl/waveform_playback.sv | 139 +++++++++++++
 1 files changed

// File: rtl/waveform_playback.sv
// Byte FIFO feeding an MSB-first serializer; back-to-back bytes leave with no
// gap so a captured byte stream replays as the original waveform.
module waveform_playback #(
  parameter int   FIFO_DEPTH = 16,
  parameter int   BIT_DIV    = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic                        enable,
  output logic                        wave_out,
  output logic                        busy,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  state_t r_state, w_state_nxt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [DW-1:0] r_div_cnt;
  logic          r_wave, r_underrun;

  logic       w_push, w_pop, w_shift, w_stop, w_underrun_nxt;
  logic       w_empty, w_div_last;
  logic [7:0] w_head;

  // Ready comes from the registered count only, never from data_valid.
  assign data_ready = (r_count != FULL);
  assign w_push     = data_valid && data_ready;
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_div_last = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_shift        = 1'b0;
    w_stop         = 1'b0;
    w_underrun_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_div_last) begin
          if (r_bit_cnt != 3'd7) begin
            w_shift = 1'b1;
          end else if (enable && !w_empty) begin
            w_pop = 1'b1;
          end else begin
            // Byte boundary with nothing to follow: starved only if still enabled.
            w_stop         = 1'b1;
            w_underrun_nxt = enable;
            w_state_nxt    = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wave     <= IDLE_LEVEL;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun_nxt;
      if (w_pop) begin
        r_wave    <= w_head[7];
        r_shift   <= {w_head[6:0], 1'b0};
        r_bit_cnt <= '0;
        r_div_cnt <= '0;
      end else if (w_shift) begin
        r_wave    <= r_shift[7];
        r_shift   <= {r_shift[6:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_div_cnt <= '0;
      end else if (w_stop) begin
        r_wave    <= IDLE_LEVEL;
        r_bit_cnt <= '0;
        r_div_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end else begin
        r_wave <= IDLE_LEVEL;
      end
    end
  end

  assign wave_out   = r_wave;
  assign busy       = (r_state == S_SHIFT);
  assign underrun   = r_underrun;
  assign fifo_count = r_count;

endmodule
